// File: rtl/conv_row_collector.sv
// Output-side collector for the conv-unit array. It walks the receptive-field
// selector through every output half-row and assembles the returned results into one output image.
module conv_row_collector #(
  parameter int DATA_WIDTH = 4,
  parameter int H          = 16,
  parameter int W          = 16,
  parameter int F          = 5
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic                                         conv_valid,
  input  logic [0:((W-F+1)/2)*DATA_WIDTH-1]            conv_out,
  output logic [5:0]                                   rowNumber,
  output logic [5:0]                                   column,
  output logic                                         conv_req,
  output logic                                         busy,
  output logic                                         done,
  output logic [0:(H-F+1)*(W-F+1)*DATA_WIDTH-1]        outputImage
);

  localparam int OH   = H - F + 1;
  localparam int OW   = W - F + 1;
  localparam int HALF = OW / 2;
  localparam logic [5:0] LAST_ROW = 6'(OH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state;
  logic   accept;
  logic [DATA_WIDTH-1:0] img [OH][OW];

  assign accept = (state == S_WAIT) && conv_valid;

  // conv_req and done are pulses raised on the edge that enters ISSUE / DONE,
  // so each stays high for exactly the one cycle spent in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      rowNumber <= '0;
      column    <= '0;
      conv_req  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      conv_req <= 1'b0;
      done     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            rowNumber <= '0;
            column    <= '0;
            busy      <= 1'b1;
            conv_req  <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (conv_valid) begin
            if (column == 6'd0) begin
              column   <= 6'd1;
              conv_req <= 1'b1;
              state    <= S_ISSUE;
            end else if (rowNumber != LAST_ROW) begin
              column    <= 6'd0;
              rowNumber <= rowNumber + 6'd1;
              conv_req  <= 1'b1;
              state     <= S_ISSUE;
            end else begin
              column    <= 6'd0;
              rowNumber <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Results land in the half-row currently selected; the address decode is a
  // compare against each (row, half) so every write target is a fixed slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < OH; r++) begin
        for (int c = 0; c < OW; c++) begin
          img[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < OH; r++) begin
        for (int h = 0; h < 2; h++) begin
          if (rowNumber == 6'(r) && column == 6'(h)) begin
            for (int j = 0; j < HALF; j++) begin
              img[r][h*HALF+j] <= conv_out[j*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
    end
  end

  for (genvar r = 0; r < OH; r++) begin : g_row
    for (genvar c = 0; c < OW; c++) begin : g_col
      assign outputImage[(r*OW+c)*DATA_WIDTH +: DATA_WIDTH] = img[r][c];
    end
  end

endmodule

// File: tb/tb_conv_row_collector.sv
// Self-checking bench for conv_row_collector: drives frames through a responder
// and compares against an image/schedule model built from the pass tables.
module tb_conv_row_collector;

  localparam int DW    = 4;
  localparam int OH    = 12;
  localparam int OW    = 12;
  localparam int HALF  = 6;
  localparam int NP    = OH * OW;
  localparam int NPASS = 2 * OH;

  logic clk = 1'b0;
  logic reset, start, conv_valid;
  logic [0:HALF*DW-1] conv_out;
  logic [5:0] rowNumber, column;
  logic conv_req, busy, done;
  logic [0:NP*DW-1] outputImage;

  int tests = 0;
  int fails = 0;

  // Stimulus tables and expected image
  logic [0:HALF*DW-1] data_tab [NPASS];
  int                 delay_tab[NPASS];
  logic [DW-1:0]      exp_img  [NP];
  int  spur_valid_k, spur_start_k, abort_k;
  bit  spur_start_done;

  // Observations recorded by run_frame
  int          obs_req_cycle[NPASS];
  logic [5:0]  obs_row[NPASS];
  logic [5:0]  obs_col[NPASS];
  int          nreq, ndone, done_cyc, busy_cnt, busy_first, busy_last, hold_err;
  bit          timed_out, aborted;
  logic [0:NP*DW-1] img_at_first_req;

  always #5 clk = ~clk;

  conv_row_collector #(.DATA_WIDTH(4), .H(16), .W(16), .F(5)) dut (
    .clk(clk), .reset(reset), .start(start), .conv_valid(conv_valid),
    .conv_out(conv_out), .rowNumber(rowNumber), .column(column),
    .conv_req(conv_req), .busy(busy), .done(done), .outputImage(outputImage)
  );

  function automatic int first_bad_pixel();
    for (int p = 0; p < NP; p++)
      if (outputImage[p*DW +: DW] !== exp_img[p]) return p;
    return -1;
  endfunction

  task automatic clear_controls();
    spur_valid_k = -1; spur_start_k = -1; abort_k = -1; spur_start_done = 0;
    for (int k = 0; k < NPASS; k++) delay_tab[k] = 0;
  endtask

  task automatic fill_pattern();
    for (int k = 0; k < NPASS; k++)
      for (int j = 0; j < HALF; j++)
        data_tab[k][j*DW +: DW] = 4'(((k/2)*12 + (k%2)*6 + j) % 16);
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < OW; c++)
        exp_img[r*OW+c] = 4'((r*12 + c) % 16);
  endtask

  task automatic fill_random(input int maxd);
    for (int k = 0; k < NPASS; k++) begin
      data_tab[k]  = 24'($urandom);
      delay_tab[k] = $urandom_range(0, maxd);
    end
  endtask

  task automatic model_from_tables();
    for (int k = 0; k < NPASS; k++)
      for (int j = 0; j < HALF; j++)
        exp_img[(k/2)*OW + (k%2)*HALF + j] = data_tab[k][j*DW +: DW];
  endtask

  // Starts a frame at cycle 0 and answers each conv_req after its table delay.
  task automatic run_frame();
    int cyc, valid_at, pend_k;
    nreq = 0; ndone = 0; done_cyc = -1; busy_cnt = 0; busy_first = -1;
    busy_last = -1; hold_err = 0; timed_out = 0; aborted = 0;
    valid_at = -1; pend_k = -1; cyc = 0;
    start = 1'b1; conv_valid = 1'b0;
    while (1) begin
      @(posedge clk); #1; cyc++;
      start = 1'b0; conv_valid = 1'b0; conv_out = 24'($urandom);
      if (busy === 1'b1) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (pend_k >= 0 && cyc <= valid_at &&
          (rowNumber !== obs_row[pend_k] || column !== obs_col[pend_k])) hold_err++;
      if (conv_req === 1'b1) begin
        if (nreq < NPASS) begin
          obs_req_cycle[nreq] = cyc;
          obs_row[nreq] = rowNumber;
          obs_col[nreq] = column;
          if (nreq == 0) img_at_first_req = outputImage;
          pend_k = nreq;
          valid_at = cyc + 1 + delay_tab[nreq];
          if (nreq == abort_k) begin
            reset = 1'b1; aborted = 1; nreq++;
            return;
          end
          if (nreq == spur_valid_k) begin
            conv_valid = 1'b1; conv_out = '1;
          end
        end
        nreq++;
      end
      if (pend_k >= 0 && cyc == valid_at) begin
        conv_valid = 1'b1; conv_out = data_tab[pend_k]; pend_k = -1;
      end
      if (spur_start_k >= 0 && pend_k == spur_start_k && cyc == obs_req_cycle[spur_start_k] + 1)
        start = 1'b1;
      if (done === 1'b1 && spur_start_done) start = 1'b1;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      if (cyc >= 400) begin timed_out = 1; break; end
    end
    start = 1'b0; conv_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; conv_valid = 1'b0; conv_out = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (outputImage !== '0) begin fails++; $display("[TB] FAIL reset_image: got nonzero image, need all zero"); end
    tests++; if (rowNumber !== 6'd0) begin fails++; $display("[TB] FAIL reset_row: got %0d need 0", rowNumber); end
    tests++; if (column !== 6'd0) begin fails++; $display("[TB] FAIL reset_col: got %0d need 0", column); end
    tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b need 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b need 0", done); end
    tests++; if (conv_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req: got %b need 0", conv_req); end
    reset = 1'b0;
  endtask

  task automatic test_full_frame();
    int bad, seq_bad;
    clear_controls(); fill_pattern();
    run_frame();
    bad = first_bad_pixel();
    tests++; if (bad !== -1) begin fails++; $display("[TB] FAIL full_image: pixel %0d got %0h need %0h", bad, outputImage[bad*DW +: DW], exp_img[bad]); end
    tests++; if (timed_out) begin fails++; $display("[TB] FAIL full_timeout: no done within bound"); end
    tests++; if (nreq !== 24) begin fails++; $display("[TB] FAIL full_req_count: got %0d need 24", nreq); end
    tests++; if (done_cyc !== 49 || ndone !== 1) begin fails++; $display("[TB] FAIL full_done: cycle %0d count %0d need cycle 49 count 1", done_cyc, ndone); end
    tests++; if (busy_first !== 1 || busy_last !== 48 || busy_cnt !== 48) begin
      fails++; $display("[TB] FAIL full_busy: first %0d last %0d count %0d need 1 48 48", busy_first, busy_last, busy_cnt); end
    seq_bad = 0;
    for (int k = 0; k < NPASS; k++)
      if (obs_row[k] !== 6'(k/2) || obs_col[k] !== 6'(k%2) || obs_req_cycle[k] !== 1 + 2*k) seq_bad++;
    tests++; if (seq_bad !== 0) begin fails++; $display("[TB] FAIL full_sequence: %0d passes with wrong row/col/cycle, need 0", seq_bad); end
  endtask

  task automatic test_stall();
    int bad;
    clear_controls(); fill_pattern();
    delay_tab[7] = 5;
    run_frame();
    bad = -1;
    for (int p = 0; p < NP; p++)
      if (bad < 0 && img_at_first_req[p*DW +: DW] !== exp_img[p]) bad = p;
    tests++; if (bad !== -1) begin fails++; $display("[TB] FAIL stall_keep_image: pixel %0d changed at first req, need previous frame value %0h", bad, exp_img[bad]); end
    tests++; if (nreq !== 24 || ndone !== 1 || done_cyc !== 54) begin
      fails++; $display("[TB] FAIL stall_frame: reqs %0d dones %0d done cycle %0d need 24 1 54", nreq, ndone, done_cyc); end
    tests++; if (obs_row[7] !== 6'd3 || obs_col[7] !== 6'd1) begin fails++; $display("[TB] FAIL stall_pass: row %0d col %0d need 3 1", obs_row[7], obs_col[7]); end
    tests++; if (obs_req_cycle[8] - obs_req_cycle[7] !== 7) begin fails++; $display("[TB] FAIL stall_gap: got %0d cycles need 7", obs_req_cycle[8] - obs_req_cycle[7]); end
    tests++; if (hold_err !== 0) begin fails++; $display("[TB] FAIL stall_hold: %0d wait cycles with moved row/col, need 0", hold_err); end
    tests++; if (obs_row[8] !== 6'd4 || obs_col[8] !== 6'd0) begin fails++; $display("[TB] FAIL stall_next: row %0d col %0d need 4 0", obs_row[8], obs_col[8]); end
    bad = first_bad_pixel();
    tests++; if (bad !== -1) begin fails++; $display("[TB] FAIL stall_image: pixel %0d got %0h need %0h", bad, outputImage[bad*DW +: DW], exp_img[bad]); end
  endtask

  task automatic test_spurious();
    int bad, idle_bad;
    idle_bad = 0;
    conv_valid = 1'b1; conv_out = '1;
    repeat (3) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || conv_req !== 1'b0) idle_bad++;
    end
    conv_valid = 1'b0;
    tests++; if (idle_bad !== 0) begin fails++; $display("[TB] FAIL idle_valid_fsm: %0d cycles with busy/req set, need 0", idle_bad); end
    bad = first_bad_pixel();
    tests++; if (bad !== -1) begin fails++; $display("[TB] FAIL idle_valid_image: pixel %0d got %0h need %0h", bad, outputImage[bad*DW +: DW], exp_img[bad]); end
    clear_controls(); fill_random(0); model_from_tables();
    spur_valid_k = 3; spur_start_k = 4; spur_start_done = 1;
    run_frame();
    bad = first_bad_pixel();
    tests++; if (bad !== -1) begin fails++; $display("[TB] FAIL spur_image: pixel %0d got %0h need %0h", bad, outputImage[bad*DW +: DW], exp_img[bad]); end
    tests++; if (nreq !== 24 || ndone !== 1 || done_cyc !== 49) begin
      fails++; $display("[TB] FAIL spur_frame: reqs %0d dones %0d done cycle %0d need 24 1 49", nreq, ndone, done_cyc); end
    tests++; if (busy_last !== 48 || busy_cnt !== 48) begin fails++; $display("[TB] FAIL spur_restart: busy last %0d count %0d need 48 48", busy_last, busy_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    clear_controls(); fill_random(1);
    abort_k = 11;
    run_frame();
    tests++; if (!aborted || obs_row[11] !== 6'd5 || obs_col[11] !== 6'd1) begin
      fails++; $display("[TB] FAIL abort_point: reached %0d row %0d col %0d need 1 5 1", aborted, obs_row[11], obs_col[11]); end
    @(posedge clk); #1;
    tests++; if (outputImage !== '0) begin fails++; $display("[TB] FAIL abort_image: got nonzero image, need all zero"); end
    tests++; if ({rowNumber, column, conv_req, busy, done} !== 15'd0) begin
      fails++; $display("[TB] FAIL abort_outputs: row %0d col %0d req %b busy %b done %b need all 0", rowNumber, column, conv_req, busy, done); end
    reset = 1'b0;
    @(posedge clk); #1;
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("[TB] FAIL abort_no_done: done %b busy %b need 0 0", done, busy); end
    clear_controls(); fill_pattern();
    run_frame();
    bad = first_bad_pixel();
    tests++; if (bad !== -1) begin fails++; $display("[TB] FAIL after_abort_image: pixel %0d got %0h need %0h", bad, outputImage[bad*DW +: DW], exp_img[bad]); end
    tests++; if (nreq !== 24 || done_cyc !== 49 || ndone !== 1) begin
      fails++; $display("[TB] FAIL after_abort_frame: reqs %0d done cycle %0d dones %0d need 24 49 1", nreq, done_cyc, ndone); end
  endtask

  task automatic test_boundary();
    int abc[6];
    logic [DW-1:0] prev137;
    abc = '{10, 11, 12, 13, 14, 15};
    clear_controls(); fill_random(0);
    data_tab[23] = 24'hABCDEF;
    prev137 = data_tab[22][5*DW +: DW];
    run_frame();
    for (int j = 0; j < HALF; j++) begin
      tests++;
      if (outputImage[(138+j)*DW +: DW] !== 4'(abc[j])) begin
        fails++; $display("[TB] FAIL boundary_pixel%0d: got %0h need %0h", 138+j, outputImage[(138+j)*DW +: DW], abc[j]); end
    end
    tests++; if (outputImage[137*DW +: DW] !== prev137) begin fails++; $display("[TB] FAIL boundary_pixel137: got %0h need %0h", outputImage[137*DW +: DW], prev137); end
    tests++; if (done_cyc !== 49 || done_cyc !== obs_req_cycle[23] + 2) begin
      fails++; $display("[TB] FAIL boundary_done: cycle %0d last req %0d need 49 and req+2", done_cyc, obs_req_cycle[23]); end
  endtask

  task automatic test_back_to_back();
    int bad, seq_bad, extra;
    for (int f = 0; f < 3; f++) begin
      clear_controls(); fill_random(3); model_from_tables();
      extra = 0;
      for (int k = 0; k < NPASS; k++) extra += delay_tab[k];
      run_frame();
      bad = first_bad_pixel();
      tests++; if (bad !== -1) begin fails++; $display("[TB] FAIL rand%0d_image: pixel %0d got %0h need %0h", f, bad, outputImage[bad*DW +: DW], exp_img[bad]); end
      tests++; if (nreq !== 24 || ndone !== 1 || done_cyc !== 49 + extra) begin
        fails++; $display("[TB] FAIL rand%0d_frame: reqs %0d dones %0d done cycle %0d need 24 1 %0d", f, nreq, ndone, done_cyc, 49 + extra); end
      tests++; if (busy_cnt !== 48 + extra || hold_err !== 0) begin
        fails++; $display("[TB] FAIL rand%0d_busy_hold: busy %0d hold errors %0d need %0d 0", f, busy_cnt, hold_err, 48 + extra); end
      seq_bad = 0;
      for (int k = 0; k < NPASS; k++)
        if (obs_row[k] !== 6'(k/2) || obs_col[k] !== 6'(k%2)) seq_bad++;
      tests++; if (seq_bad !== 0) begin fails++; $display("[TB] FAIL rand%0d_sequence: %0d wrong passes need 0", f, seq_bad); end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; conv_valid = 1'b0; conv_out = '0;
    clear_controls();
    test_reset();
    test_full_frame();
    test_stall();
    test_spurious();
    test_reset_mid_frame();
    test_boundary();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout need completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/conv_row_collector.md
Name: conv_row_collector

Overview:
- Output-side counterpart of the receptive-field selector.
- Sequences the selector through every output row and column-half by driving rowNumber/column, and requests a conv pass per half-row.
- Collects the HALF parallel conv results per pass and assembles them into the complete output feature map.
- Sits between the conv-unit array and the next layer (pooling / next conv stage).

Parameters:
- DATA_WIDTH, 4, width of one pixel/result.
- H, 16, input image height.
- W, 16, input image width.
- F, 5, filter size.
- Derived (localparam): OH = H-F+1 = 12, OW = W-F+1 = 12, HALF = OW/2 = 6.
- Constraints: OW even; OH <= 64.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse, begins a frame
- conv_valid  input  1  conv results on conv_out are valid this cycle
- conv_out  input  HALF*DATA_WIDTH  results, [0:...] ordering; element j at bits [j*DATA_WIDTH +: DATA_WIDTH] = output column column*HALF+j
- rowNumber  output  6  output row currently requested (to selector)
- column  output  6  half select to selector: 0 = first half, 1 = second half
- conv_req  output  1  one-cycle pulse: selector inputs are stable, start conv pass
- busy  output  1  high from the cycle after start until DONE
- done  output  1  one-cycle pulse, frame complete
- outputImage  output  OH*OW*DATA_WIDTH  [0:...] row-major; pixel (r,c) at bits [(r*OW+c)*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- All outputs are registered.
- Reset: state=IDLE; rowNumber, column, conv_req, busy, done = 0; outputImage all zero.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - busy=0.
  - On start: rowNumber<=0, column<=0, busy<=1, go ISSUE.
  - outputImage is not cleared on start; every pixel is overwritten during the frame.
- ISSUE: conv_req=1 for exactly this cycle; go WAIT.
- WAIT:
  - conv_req=0. Holds indefinitely until conv_valid=1.
  - On conv_valid, in the same edge:
    - Write conv_out element j into pixel (rowNumber, column*HALF+j), j = 0..HALF-1.
    - If column==0: column<=1, go ISSUE.
    - If column==1 and rowNumber<OH-1: column<=0, rowNumber<=rowNumber+1, go ISSUE.
    - If column==1 and rowNumber==OH-1: column<=0, rowNumber<=0, busy<=0, go DONE.
- DONE: done=1 for this cycle only; go IDLE.
- rowNumber/column change only on a WAIT-state conv_valid edge (or on start/reset). They are stable from ISSUE through the accepting WAIT cycle.
- Ignored inputs:
  - conv_valid in IDLE, ISSUE or DONE, including coincident with conv_req.
  - start while not in IDLE (including the DONE cycle).
- No arithmetic: conv_out is stored bit-exact, with no truncation or saturation.
- Timing, with start sampled at cycle 0 and conv_valid returned in the first WAIT cycle:
  - Half k has ISSUE at cycle 1+2k and WAIT at cycle 2+2k.
  - Last write is at cycle 48; done is high at cycle 49.
  - Minimum frame time is 2*2*OH+2 cycles.
- Reset mid-frame: returns to the reset state on the next edge with no done pulse; partial outputImage is zeroed.

Test Plan:
1. Reset: assert reset 2 cycles -> outputImage==0, rowNumber=0, column=0, busy=0, done=0, conv_req=0.
2. Full frame, zero-delay responder:
   - Stimulus: start at cycle 0. Responder drives conv_valid in the cycle after each conv_req, with element j = (rowNumber*12 + column*6 + j) mod 16.
   - Expect: pixel (r,c) == (r*12+c) mod 16 for all 144 pixels; 24 conv_req pulses; done at cycle 49 only; busy high cycles 1-48.
3. Stall:
   - Stimulus: delay conv_valid 5 cycles after conv_req for row 3, column 1.
   - Expect: conv_req stays a single pulse; rowNumber=3 and column=1 held all 6 WAIT cycles; next conv_req carries row 4, column 0.
4. Spurious inputs:
   - Stimulus: conv_valid=1 in IDLE with conv_out=all-ones; conv_valid coincident with a conv_req; start pulsed at row 2.
   - Expect: no pixel changes, no FSM advance, no frame restart.
5. Reset mid-frame:
   - Stimulus: reset at rowNumber=5, column=1.
   - Expect: next cycle all outputs 0 and no done; a fresh start then completes a correct frame per scenario 2.
6. Boundary write:
   - Stimulus: final pass (row 11, column 1) with conv_out = 0xABCDEF.
   - Expect: pixels 138..143 = A,B,C,D,E,F; pixel 137 untouched; done on the following cycle.
